// File: rtl/gpio_access_arbiter_pkg.sv
// Shared constants and state encoding for the GPIO access arbiter.
// The GPIO peripheral exposes two registers: a writable output register and a read-only input register.
package gpio_access_arbiter_pkg;

  localparam logic GPIO_ADDR_OUT = 1'b0;
  localparam logic GPIO_ADDR_IN  = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/gpio_access_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_access_arbiter.sv
// Shares the single GPIO port between NUM_REQ masters: round-robin, one access in flight,
// fixed IDLE -> ACCESS -> DONE sequence, writes to the read-only input register are dropped.
module gpio_access_arbiter
  import gpio_access_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          err,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          gpio_en,
  output logic                          gpio_addr,
  output logic [DATA_WIDTH-1:0]         gpio_wdata,
  input  logic [DATA_WIDTH-1:0]         gpio_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e                state_q, state_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [IDX_W-1:0]          win_q, win_d;
  logic [NUM_REQ-1:0]        gnt_q, gnt_d;
  logic                      we_q, we_d;
  logic                      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic [NUM_REQ-1:0]        pick_gnt;
  logic [IDX_W-1:0]          pick_idx;
  logic                      pick_any;
  logic                      in_access;
  logic                      in_done;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= GPIO_ADDR_OUT;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Operands are latched in IDLE so requester changes mid-access are invisible.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          win_d   = pick_idx;
          gnt_d   = pick_gnt;
          we_d    = req_we[pick_idx];
          addr_d  = req_addr[pick_idx];
          wdata_d = req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          state_d = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        rdata_d = we_q ? '0 : gpio_rdata;
        err_d   = we_q & (addr_q == GPIO_ADDR_IN);
        ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
        state_d = ARB_DONE;
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  assign in_access = (state_q == ARB_ACCESS);
  assign in_done   = (state_q == ARB_DONE);

  // Reset arriving during ACCESS must suppress the write at that same edge.
  assign gpio_en    = in_access & we_q & (addr_q == GPIO_ADDR_OUT) & ~rst;
  assign gpio_addr  = in_access ? addr_q : GPIO_ADDR_OUT;
  assign gpio_wdata = in_access ? wdata_q : '0;
  assign ack        = in_done ? gnt_q : '0;
  assign err        = in_done & err_q;
  assign rdata      = in_done ? rdata_q : '0;

endmodule

// File: tb/tb_gpio_access_arbiter.sv
// Scoreboard bench for gpio_access_arbiter with a small GPIO register model attached.
module tb_gpio_access_arbiter;

  localparam int NR = 2;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR-1:0]    req_we = '0;
  logic [NR-1:0]    req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    ack;
  logic             err;
  logic [DW-1:0]    rdata;
  logic             gpio_en;
  logic             gpio_addr;
  logic [DW-1:0]    gpio_wdata;
  logic [DW-1:0]    gpio_rdata;

  logic [DW-1:0]    portOut = '0;
  logic [7:0]       portIn = 8'h00;
  int               writeCount = 0;

  typedef struct {
    logic [NR-1:0] ack;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  gpio_access_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .ack        (ack),
    .err        (err),
    .rdata      (rdata),
    .gpio_en    (gpio_en),
    .gpio_addr  (gpio_addr),
    .gpio_wdata (gpio_wdata),
    .gpio_rdata (gpio_rdata)
  );

  always #5 clk = ~clk;

  // GPIO peripheral model: output register written on en, input register read combinationally.
  assign gpio_rdata = gpio_addr ? {24'h0, portIn} : portOut;

  always @(posedge clk) begin
    if (gpio_en) begin
      writeCount <= writeCount + 1;
      if (gpio_addr == 1'b0) portOut <= gpio_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ack !== '0) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_ack: got ack=%b expected no ack", ack);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sb_ack", DW'(ack), DW'(e.ack));
        checkOutput("sb_err", DW'(err), DW'(e.err));
        checkOutput("sb_rdata", rdata, e.rdata);
      end
    end
  end

  task automatic pushExp(input logic [NR-1:0] a, input logic e, input logic [DW-1:0] d);
    exp_t x;
    x.ack = a;
    x.err = e;
    x.rdata = d;
    sb.push_back(x);
  endtask

  task automatic applyStimulus(input int r, input bit we, input bit addr, input logic [DW-1:0] wd,
                               input bit expErr, input logic [DW-1:0] expRd, output int lat);
    pushExp(NR'(1) << r, expErr, expRd);
    @(negedge clk);
    req[r] = 1'b1;
    req_we[r] = we;
    req_addr[r] = addr;
    req_wdata[r*DW +: DW] = wd;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ack[r]) begin
        lat = c;
        break;
      end
    end
    req[r] = 1'b0;
    if (lat < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL ack_timeout: got no ack expected ack from requester %0d", r);
    end
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ack"}, DW'(ack), '0);
    checkOutput({tag, "_err"}, DW'(err), '0);
    checkOutput({tag, "_rdata"}, rdata, '0);
    checkOutput({tag, "_en"}, DW'(gpio_en), '0);
    checkOutput({tag, "_addr"}, DW'(gpio_addr), '0);
    checkOutput({tag, "_wdata"}, gpio_wdata, '0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int lat;
    int wc;
    int ackTimes[$];
    logic [DW-1:0] capRdata;
    logic [DW-1:0] capWdata;
    logic          capEn;

    doReset(3);
    checkIdleOutputs("reset");

    // Legal write to the output register: one en pulse, ack two cycles after the request.
    wc = writeCount;
    capEn = 1'b0;
    capWdata = '0;
    pushExp(2'b01, 1'b0, '0);
    @(negedge clk);
    req[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 1'b0; req_wdata[0 +: DW] = 32'hA5;
    @(negedge clk);
    capEn = gpio_en;
    capWdata = gpio_wdata;
    @(negedge clk);
    checkOutput("t1_ack_latency", DW'(ack), 32'h1);
    req[0] = 1'b0;
    checkOutput("t1_gpio_en_access", DW'(capEn), 32'h1);
    checkOutput("t1_gpio_wdata", capWdata, 32'hA5);
    checkOutput("t1_write_count", DW'(writeCount - wc), 32'd1);
    checkOutput("t1_port_out", portOut, 32'hA5);

    applyStimulus(1, 1'b0, 1'b0, '0, 1'b0, 32'h0000_00A5, lat);
    checkOutput("t2_latency", DW'(lat), 32'd2);

    // Write to the read-only input register is dropped and flagged.
    wc = writeCount;
    applyStimulus(0, 1'b1, 1'b1, 32'hFF, 1'b1, '0, lat);
    checkOutput("t4_write_count", DW'(writeCount - wc), 32'd0);
    checkOutput("t4_port_out", portOut, 32'hA5);

    portIn = 8'h3C;
    applyStimulus(1, 1'b0, 1'b1, '0, 1'b0, 32'h0000_003C, lat);
    checkOutput("t5_latency", DW'(lat), 32'd2);

    // Contention from reset: both held, grants alternate 0,1,0,1 three cycles apart.
    doReset(2);
    pushExp(2'b01, 1'b0, 32'h0000_00A5);
    pushExp(2'b10, 1'b0, 32'h0000_003C);
    pushExp(2'b01, 1'b0, 32'h0000_00A5);
    pushExp(2'b10, 1'b0, 32'h0000_003C);
    @(negedge clk);
    req = 2'b11; req_we = 2'b00; req_addr = 2'b10;
    for (int c = 1; c <= 30 && ackTimes.size() < 4; c++) begin
      @(negedge clk);
      if (ack !== '0) ackTimes.push_back(c);
    end
    req = 2'b00;
    checkOutput("t3_ack_count", DW'(ackTimes.size()), 32'd4);
    if (ackTimes.size() == 4) begin
      checkOutput("t3_first_latency", DW'(ackTimes[0]), 32'd2);
      for (int k = 1; k < 4; k++)
        checkOutput("t3_spacing", DW'(ackTimes[k] - ackTimes[k-1]), 32'd3);
    end

    // Reset during ACCESS of a write: no GPIO write, no ack, pointer back to 0.
    repeat (2) @(negedge clk);
    wc = writeCount;
    @(negedge clk);
    req[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 1'b0; req_wdata[0 +: DW] = 32'h5A;
    @(negedge clk);
    rst = 1'b1;
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkIdleOutputs("t6_after_reset");
    checkOutput("t6_write_count", DW'(writeCount - wc), 32'd0);
    checkOutput("t6_port_out", portOut, 32'hA5);
    pushExp(2'b01, 1'b0, 32'h0000_00A5);
    @(negedge clk);
    req = 2'b11; req_we = 2'b00; req_addr = 2'b10;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ack !== '0) begin
        lat = c;
        break;
      end
    end
    req = 2'b00;
    checkOutput("t6_post_latency", DW'(lat), 32'd2);

    repeat (4) @(negedge clk);
    checkOutput("sb_drained", DW'(sb.size()), 32'd0);
    capRdata = rdata;
    checkOutput("final_idle_rdata", capRdata, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
